// File: rtl/rx_frame_ctrl.sv
// Receive framing controller: start detect, mid-bit shift strobes, stop check and held output word.
// Define RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module rx_frame_ctrl #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS-1:0] sr_data,
    input  logic                 data_read,
    output logic                 serial_sync,
    output logic                 sr_shift_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 parity_error
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_HALF  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_STOP  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
`ifdef RX_PARITY_EN
        PARITY,
`endif
        STOP_CHK,
        LOAD
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            sync1;
    logic            sync2;
    logic            hist;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bit_cnt;
    logic            start_edge;
    logic            bit_done;
    logic            cnt_clr;
    logic            load_now;
    logic            frame_err_now;
    logic            par_bad;

    // Flops preset high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 1'b1;
        end else begin
            sync1 <= serial_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign serial_sync = sync2;
    assign start_edge  = ~sync2 & hist;
    assign bit_done    = (state == DATA) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nxt = START_CHK;
                end
            end
            START_CHK: begin
                if (cnt == CNT_HALF) begin
                    state_nxt = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_cnt == BITS_LAST)) begin
`ifdef RX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP_CHK;
`endif
                end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = STOP_CHK;
                end
            end
`endif
            // Leave one count early so the LOAD cycle itself is the mid-stop sample.
            STOP_CHK: begin
                if (cnt == CNT_STOP) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        sr_shift_enable = 1'b0;
        load_now        = 1'b0;
        frame_err_now   = 1'b0;
        cnt_clr         = (state_nxt != state) || bit_done;
        case (state)
            DATA: begin
                sr_shift_enable = bit_done & ~rst;
            end
            LOAD: begin
                load_now      = sync2 & ~par_bad;
                frame_err_now = ~sync2;
            end
            default: begin
                sr_shift_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
        end else begin
            if ((state == IDLE) || cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end
    end

`ifdef RX_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
        end else begin
            if ((state == IDLE) && start_edge) begin
                par_bad <= 1'b0;
            end else if ((state == PARITY) && (cnt == CNT_LAST)) begin
                par_bad <= ^{sr_data, sync2};
            end
            if ((state == IDLE) && start_edge) begin
                par_err_q <= 1'b0;
            end else if ((state == LOAD) && sync2 && par_bad) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign parity_error = par_err_q;
`else
    assign par_bad      = 1'b0;
    assign parity_error = 1'b0;
`endif

    // A load in the same cycle as a read keeps the new word marked ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if ((state == IDLE) && start_edge) begin
                framing_error <= 1'b0;
            end else if (frame_err_now) begin
                framing_error <= 1'b1;
            end
            if (load_now) begin
                rx_data       <= sr_data;
                data_ready    <= 1'b1;
                overrun_error <= data_ready & ~data_read;
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: frame-level reference model plus literal pins on directed frames.
module tb_rx_frame_ctrl;

    localparam int D    = 8;
    localparam int C    = 10;
    localparam int H    = 5;
`ifdef RX_PARITY_EN
    localparam int P    = 1;
`else
    localparam int P    = 0;
`endif
    localparam int MAXC = 30000;
    localparam int NPIN = 96;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         serial_in = 1'b0;
    logic         data_read = 1'b0;
    logic [D-1:0] sr_data = '0;
    logic         serial_sync;
    logic         sr_shift_enable;
    logic [D-1:0] rx_data;
    logic         data_ready;
    logic         overrun_error;
    logic         framing_error;
    logic         parity_error;

    rx_frame_ctrl #(.DATA_BITS(D), .CLKS_PER_BIT(C)) dut (
        .clk             (clk),
        .rst             (rst),
        .serial_in       (serial_in),
        .sr_data         (sr_data),
        .data_read       (data_read),
        .serial_sync     (serial_sync),
        .sr_shift_enable (sr_shift_enable),
        .rx_data         (rx_data),
        .data_ready      (data_ready),
        .overrun_error   (overrun_error),
        .framing_error   (framing_error),
        .parity_error    (parity_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External LSB-first shift register fed from the synchronized line.
    always @(posedge clk) if (sr_shift_enable) sr_data <= {serial_sync, sr_data[D-1:1]};

    int total = 0;
    int bad   = 0;
    int t_now = 0;

    task automatic chk(input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, t_now, act, want);
        end
    endtask

    int pin_cyc  [NPIN];
    int pin_kind [NPIN];
    int pin_val  [NPIN];
    bit pin_done [NPIN];
    int n_pins = 0;

    task automatic pin(input int c, input int kind, input int val);
        pin_cyc[n_pins]  = c;
        pin_kind[n_pins] = kind;
        pin_val[n_pins]  = val;
        pin_done[n_pins] = 1'b0;
        n_pins++;
    endtask

    // Reference model: line history arrays and a per-frame schedule.
    bit           sin_a  [MAXC];
    bit           rst_a  [MAXC];
    bit           sync_a [MAXC];
    int           t;
    int           idle_from = 0;
    int           e_cyc = 0;
    bit           started = 0;
    bit           ms, mh, rd, edge_now, exp_stb, m_load, m_ferr, m_perr, m_par;
    logic [D-1:0] m_bits = '0;
    int           off, k, act;
    string        pnm;
    logic [D-1:0] e_rx = '0;
    bit           e_rdy = 0, e_ovr = 0, e_fe = 0, e_pe = 0;

    always @(negedge clk) begin
        t_now = cyc;
        if (cyc < MAXC) begin
            t = cyc;
            rst_a[t] = rst;
            sin_a[t] = serial_in;
            rd       = data_read;
            if (t < 2) ms = 1'b1;
            else       ms = (rst_a[t-1] || rst_a[t-2]) ? 1'b1 : sin_a[t-2];
            sync_a[t] = ms;
            mh = (t < 1 || rst_a[t-1]) ? 1'b1 : sync_a[t-1];
            edge_now = 0; exp_stb = 0; m_load = 0; m_ferr = 0; m_perr = 0;
            if (rst) begin
                idle_from = t + 1;
                started   = 0;
            end else if (t >= idle_from) begin
                if (!ms && mh) begin
                    edge_now  = 1;
                    e_cyc     = t;
                    idle_from = 2 * MAXC;
                    started   = 0;
                end
            end else if (t == e_cyc + H) begin
                if (ms) idle_from = t + 1;
                else    started   = 1;
            end else if (started) begin
                off = t - (e_cyc + H);
                if (off % C == 0) begin
                    k = off / C;
                    if (k <= D) begin
                        exp_stb     = 1;
                        m_bits[k-1] = ms;
                    end else if (P == 1 && k == D + 1) begin
                        m_par = ms;
                    end else begin
                        idle_from = t + 1;
                        if (!ms)                              m_ferr = 1;
                        else if (P == 1 && ((^m_bits) ^ m_par)) m_perr = 1;
                        else                                  m_load = 1;
                    end
                end
            end

            if (t > 0) begin
                for (int i = 0; i < n_pins; i++) begin
                    if (!pin_done[i] && pin_cyc[i] == t) begin
                        pin_done[i] = 1'b1;
                        case (pin_kind[i])
                            0:       begin pnm = "pin_shift";   act = int'(sr_shift_enable); end
                            1:       begin pnm = "pin_ready";   act = int'(data_ready);      end
                            2:       begin pnm = "pin_rx_data"; act = int'(rx_data);         end
                            3:       begin pnm = "pin_overrun"; act = int'(overrun_error);   end
                            4:       begin pnm = "pin_framing"; act = int'(framing_error);   end
                            5:       begin pnm = "pin_parity";  act = int'(parity_error);    end
                            default: begin pnm = "pin_sync";    act = int'(serial_sync);     end
                        endcase
                        chk(pnm, act, pin_val[i]);
                    end
                end
                chk("serial_sync", int'(serial_sync), int'(ms));
                chk("shift_strobe", int'(sr_shift_enable), int'(exp_stb));
                chk("rx_data", int'(rx_data), int'(e_rx));
                chk("data_ready", int'(data_ready), int'(e_rdy));
                chk("overrun_error", int'(overrun_error), int'(e_ovr));
                chk("framing_error", int'(framing_error), int'(e_fe));
                chk("parity_error", int'(parity_error), int'(e_pe));
            end

            if (rst) begin
                e_rx = '0; e_rdy = 0; e_ovr = 0; e_fe = 0; e_pe = 0;
            end else begin
                if (edge_now) begin e_fe = 0; e_pe = 0; end
                if (m_ferr) e_fe = 1;
                if (m_perr) e_pe = 1;
                if (m_load) begin
                    e_rx = m_bits;
                    if (e_rdy && !rd) e_ovr = 1;
                    else if (rd)      e_ovr = 0;
                    e_rdy = 1;
                end else if (rd) begin
                    e_rdy = 0;
                    e_ovr = 0;
                end
            end
        end
    end

    int force_rd = -1;
    bit rd_rand  = 0;
    int e;

    task automatic tick(input bit line, input bit r);
        @(posedge clk);
        #1;
        rst       = r;
        serial_in = line;
        data_read = (cyc == force_rd) || (rd_rand && ($urandom_range(0, 29) == 0));
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [D-1:0] d, input bit stop, input bit pbit, input int abort_j);
        int j;
        bit v;
        j = 0;
        for (int b = 0; b < D + 2 + P; b++) begin
            if (b == 0)                    v = 1'b0;
            else if (b <= D)               v = d[b-1];
            else if (P == 1 && b == D + 1) v = pbit;
            else                           v = stop;
            for (int c = 0; c < C; c++) begin
                if (j == abort_j) begin
                    tick(v, 1'b1);
                    return;
                end
                tick(v, 1'b0);
                j++;
            end
        end
    endtask

    function automatic bit par_of(input logic [D-1:0] d);
        return ^d;
    endfunction

    logic [D-1:0] rd_d;
    int           lat;

    initial begin
        lat = 96 + P * C;
        pin(3, 6, 1); pin(4, 6, 1);
        pin(3, 0, 0); pin(3, 1, 0); pin(3, 2, 0); pin(3, 3, 0); pin(3, 4, 0); pin(3, 5, 0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        idle(20);

        e = cyc + 3;
        pin(e + 14, 0, 0); pin(e + 15, 0, 1); pin(e + 25, 0, 1); pin(e + 85, 0, 1);
        pin(e + lat - 1, 1, 0); pin(e + lat, 1, 1); pin(e + lat, 2, 'hA5);
        pin(e + lat, 3, 0); pin(e + lat, 4, 0);
        send_frame(8'hA5, 1'b1, par_of(8'hA5), -1);
        force_rd = cyc + 2; pin(cyc + 3, 1, 0);
        idle(10);

        e = cyc + 3;
        pin(e + 10, 4, 0); pin(e + 15, 0, 0);
        repeat (3) tick(1'b0, 1'b0);
        idle(20);

        e = cyc + 3;
        pin(e + lat - 1, 4, 0); pin(e + lat, 4, 1); pin(e + lat, 1, 0); pin(e + lat, 2, 'hA5);
        send_frame(8'h3C, 1'b0, par_of(8'h3C), -1);
        idle(10);
        e = cyc + 3;
        pin(e, 4, 1); pin(e + 1, 4, 0); pin(e + lat, 2, 'h5A);
        send_frame(8'h5A, 1'b1, par_of(8'h5A), -1);
        force_rd = cyc + 2; pin(cyc + 3, 1, 0);
        idle(10);

        e = cyc + 3;
        pin(e + lat, 1, 1); pin(e + lat, 3, 0); pin(e + lat, 2, 'h11);
        send_frame(8'h11, 1'b1, par_of(8'h11), -1);
        e = cyc + 3;
        pin(e + lat, 1, 1); pin(e + lat, 3, 1); pin(e + lat, 2, 'h22);
        send_frame(8'h22, 1'b1, par_of(8'h22), -1);
        force_rd = cyc + 2; pin(cyc + 2, 3, 1); pin(cyc + 3, 1, 0); pin(cyc + 3, 3, 0);
        idle(10);
        send_frame(8'h33, 1'b1, par_of(8'h33), -1);
        idle(3);
        e = cyc + 3;
        force_rd = e + lat - 1;
        pin(e + lat, 1, 1); pin(e + lat, 3, 0); pin(e + lat, 2, 'h44);
        send_frame(8'h44, 1'b1, par_of(8'h44), -1);
        idle(5);

`ifdef RX_PARITY_EN
        e = cyc + 3;
        pin(e + 105, 5, 0); pin(e + 106, 5, 1); pin(e + 106, 2, 'h44);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        idle(5);
        e = cyc + 3;
        pin(e, 5, 1); pin(e + 1, 5, 0); pin(e + 106, 2, 'h07); pin(e + 106, 5, 0);
        send_frame(8'h07, 1'b1, 1'b1, -1);
        idle(5);
`endif

        e = cyc + 3;
        pin(e + 15, 0, 1); pin(e + 25, 0, 0); pin(e + 26, 1, 0); pin(e + 26, 2, 0);
        send_frame(8'h96, 1'b1, par_of(8'h96), 27);
        idle(20);

        rd_rand = 1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 4)) tick(1'b0, 1'b0);
                idle(10);
            end else begin
                rd_d = D'($urandom);
                send_frame(rd_d, ($urandom_range(0, 9) != 0),
                           par_of(rd_d) ^ ($urandom_range(0, 7) == 0), -1);
                idle($urandom_range(0, 12));
            end
        end
        rd_rand = 0;
        idle(150);

        for (int i = 0; i < n_pins; i++) begin
            if (!pin_done[i]) begin
                total++;
                bad++;
                $display("FAIL pin_unreached kind=%0d: got none expected check at cycle %0d",
                         pin_kind[i], pin_cyc[i]);
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
